// File: rtl/hada_abs_signum_pipe.sv
// hada_abs_signum_pipe: streaming |a| / signum(a) for any WIDTH, signed or
// unsigned per transaction, with a STAGES-deep valid/ready pipeline.
//
// Build option: define HADA_ABS_SAT_EN to make abs of the most-negative
// signed value return max positive (0 followed by ones). Left undefined,
// that case wraps to the input value, matching plain two's-complement
// negation. out_ovf is raised in both builds.
//
// Handshake: a word moves on a rising edge when valid & ready are both
// high on that side. Once out_valid rises, out_data/out_ovf hold until the
// consumer takes them. in_ready is a combinational chain back from
// out_ready through the stage valid bits (no skid buffer).
module hada_abs_signum_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_op,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS = ~MIN_NEG;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] r_ovf;
  logic [WIDTH-1:0]  r_data [STAGES];
  logic [CNT_W-1:0]  r_cnt;

  logic [STAGES-1:0] w_en;
  logic              w_neg;
  logic              w_is_min;
  logic [WIDTH-1:0]  w_res;
  logic              w_ovf;
  logic              w_out_xfer;

  // Per-stage load enable: a stage loads when empty or when its content
  // moves downstream this cycle; evaluated from the output end backwards.
  always_comb begin
    logic v_take;
    v_take = out_ready;
    w_en   = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      v_take  = ~r_vld[k] | v_take;
      w_en[k] = v_take;
    end
  end

  // Stage-0 arithmetic: abs or signum of the incoming operand.
  always_comb begin
    w_neg    = in_signed & in_data[WIDTH-1];
    w_is_min = (in_data == MIN_NEG);
    w_res    = '0;
    w_ovf    = 1'b0;
    if (!in_op) begin
      if (w_neg) begin
        if (w_is_min) begin
          w_ovf = 1'b1;
`ifdef HADA_ABS_SAT_EN
          w_res = MAX_POS;
`else
          w_res = in_data;
`endif
        end else begin
          w_res = ~in_data + ONE;
        end
      end else begin
        w_res = in_data;
      end
    end else begin
      if (in_data == '0) begin
        w_res = '0;
      end else if (w_neg) begin
        w_res = '1;
      end else begin
        w_res = ONE;
      end
    end
  end

  // Pipeline registers: stage 0 takes the computed result, later stages
  // shift the previous stage forward; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_ovf <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      if (w_en[0]) begin
        r_vld[0]  <= in_valid;
        r_ovf[0]  <= w_ovf;
        r_data[0] <= w_res;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_en[k]) begin
          r_vld[k]  <= r_vld[k-1];
          r_ovf[k]  <= r_ovf[k-1];
          r_data[k] <= r_data[k-1];
        end
      end
    end
  end

  assign w_out_xfer = r_vld[STAGES-1] & out_ready;

  // Saturating count of overflow results handed to the consumer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_out_xfer && r_ovf[STAGES-1] && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = rst_n & w_en[0];
  assign out_valid = r_vld[STAGES-1];
  assign out_data  = r_data[STAGES-1];
  assign out_ovf   = r_ovf[STAGES-1];
  assign ovf_cnt   = r_cnt;

endmodule

// File: tb/tb_hada_abs_signum_pipe.sv
// Bench for hada_abs_signum_pipe at WIDTH=8, STAGES=2, CNT_W=2.
// Directed scenarios followed by randomized traffic with random
// backpressure; a negedge monitor scoreboards every output transfer.
module tb_hada_abs_signum_pipe;

  localparam int W  = 8;
  localparam int ST = 2;
  localparam int CW = 2;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_op;
  logic          in_signed;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_ovf;
  logic [CW-1:0] ovf_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [W:0]    exp_q[$];
  int            exp_cnt = 0;
  logic          hold_pend = 1'b0;
  logic [W:0]    hold_val;
  logic          rnd_done;

`ifdef HADA_ABS_SAT_EN
  localparam logic [W-1:0] MIN_ABS = 8'h7F;
`else
  localparam logic [W-1:0] MIN_ABS = 8'h80;
`endif

  hada_abs_signum_pipe #(.WIDTH(W), .STAGES(ST), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .ovf_cnt   (ovf_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference: {ovf, result} from plain integer arithmetic
  function automatic logic [W:0] ref_calc(input logic [W-1:0] a, input logic op, input logic sgn);
    int v;
    int r;
    logic ovf;
    ovf = 1'b0;
    v = (sgn && a[W-1]) ? int'(a) - (1 << W) : int'(a);
    if (!op) begin
      r = (v < 0) ? -v : v;
      if (r == (1 << (W - 1)) && sgn) begin
        ovf = 1'b1;
        r = int'(MIN_ABS);
      end
    end else begin
      r = (v > 0) ? 1 : ((v == 0) ? 0 : (1 << W) - 1);
    end
    return {ovf, W'(r)};
  endfunction

  // scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    logic [W:0] e;
    if (!rst_n) begin
      check("in_ready_in_reset", in_ready, 0);
      exp_q.delete();
      exp_cnt   = 0;
      hold_pend = 1'b0;
    end else begin
      check("ovf_cnt", ovf_cnt, exp_cnt);
      if (hold_pend) begin
        check("hold_valid", out_valid, 1);
        check("hold_stable", {out_ovf, out_data}, hold_val);
      end
      if (in_valid && in_ready) exp_q.push_back(ref_calc(in_data, in_op, in_signed));
      if (out_valid && out_ready) begin
        hold_pend = 1'b0;
        if (exp_q.size() == 0) begin
          check("spurious_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e[W-1:0]);
          check("out_ovf", out_ovf, e[W]);
          if (e[W] && exp_cnt < (1 << CW) - 1) exp_cnt++;
        end
      end else if (out_valid) begin
        hold_pend = 1'b1;
        hold_val  = {out_ovf, out_data};
      end
    end
  end

  // driver tasks
  task automatic send(input logic [W-1:0] a, input logic op, input logic sgn);
    logic acc;
    in_valid  = 1'b1;
    in_data   = a;
    in_op     = op;
    in_signed = sgn;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      if (i == 199) check("send_timeout", 1, 0);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic [W-1:0] ed, input logic eo);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check({tag, "_valid"}, out_valid, 1);
    check(tag, out_data, ed);
    check({tag, "_ovf"}, out_ovf, eo);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [W-1:0] bp_items [4];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_op     = 1'b0;
    in_signed = 1'b0;
    out_ready = 1'b1;
    rnd_done  = 1'b0;
    @(posedge clk);
    #1;
    do_reset(3);

    // reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_ovf_cnt", ovf_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // basic abs: FB, 05, 00 back to back, results on cycles 2, 3, 4
    in_valid = 1'b1; in_op = 1'b0; in_signed = 1'b1; in_data = 8'hFB;
    @(negedge clk);
    check("lat_c0_ready", in_ready, 1);
    check("lat_c0_valid", out_valid, 0);
    @(posedge clk); #1; in_data = 8'h05;
    @(negedge clk);
    check("lat_c1_valid", out_valid, 0);
    @(posedge clk); #1; in_data = 8'h00;
    @(negedge clk);
    check("lat_c2_valid", out_valid, 1);
    check("lat_c2_data", out_data, 8'h05);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    check("lat_c3_valid", out_valid, 1);
    check("lat_c3_data", out_data, 8'h05);
    @(negedge clk);
    check("lat_c4_valid", out_valid, 1);
    check("lat_c4_data", out_data, 8'h00);
    check("lat_c4_ovf", out_ovf, 0);
    @(negedge clk);
    check("lat_c5_valid", out_valid, 0);
    @(posedge clk); #1;

    // signum, signed and unsigned
    send(8'h80, 1'b1, 1'b1); wait_out("sgn_s_80", 8'hFF, 1'b0);
    send(8'h01, 1'b1, 1'b1); wait_out("sgn_s_01", 8'h01, 1'b0);
    send(8'h00, 1'b1, 1'b1); wait_out("sgn_s_00", 8'h00, 1'b0);
    send(8'h80, 1'b1, 1'b0); wait_out("sgn_u_80", 8'h01, 1'b0);
    send(8'h00, 1'b1, 1'b0); wait_out("sgn_u_00", 8'h00, 1'b0);

    // overflow case and unsigned passthrough
    send(8'h80, 1'b0, 1'b1); wait_out("abs_s_min", MIN_ABS, 1'b1);
    @(negedge clk);
    check("ovf_cnt_after_min", ovf_cnt, 1);
    @(posedge clk); #1;
    send(8'h80, 1'b0, 1'b0); wait_out("abs_u_80", 8'h80, 1'b0);
    send(8'h81, 1'b0, 1'b1); wait_out("abs_s_81", 8'h7F, 1'b0);

    // backpressure: two accepts then stall for five cycles
    bp_items[0] = 8'hF0; bp_items[1] = 8'h10; bp_items[2] = 8'h80; bp_items[3] = 8'h7F;
    out_ready = 1'b0;
    begin
      int idx;
      idx = 0;
      for (int c = 0; c < 7; c++) begin
        in_valid = 1'b1; in_op = 1'b0; in_signed = 1'b1; in_data = bp_items[idx];
        @(negedge clk);
        if (c < 2) begin
          check("bp_accept", in_ready, 1);
        end else begin
          check("bp_stalled", in_ready, 0);
          check("bp_out_data", out_data, 8'h10);
        end
        if (in_ready) idx++;
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = idx; i < 4; i++) send(bp_items[i], 1'b0, 1'b1);
    end
    drain();

    // reset with two overflow transactions in flight
    send(8'h80, 1'b0, 1'b1);
    send(8'h80, 1'b0, 1'b1);
    do_reset(1);
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_ovf_cnt", ovf_cnt, 0);
    repeat (4) @(posedge clk);
    #1;

    // counter saturation
    for (int i = 0; i < 6; i++) send(8'h80, 1'b0, 1'b1);
    drain();
    @(negedge clk);
    check("sat_ovf_cnt", ovf_cnt, 3);
    @(posedge clk); #1;

    // randomized traffic with random backpressure
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          logic [W-1:0] d;
          int sel;
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          sel = $urandom_range(0, 7);
          case (sel)
            0: d = 8'h80;
            1: d = 8'h00;
            2: d = 8'h7F;
            3: d = 8'hFF;
            default: d = W'($urandom_range(0, 255));
          endcase
          send(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
